// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one RV32I ALU decoder + ALU between two requesters: the execute
// stage (requester 0) and the branch/address unit (requester 1). One request
// is granted per cycle, its operands are registered in stage S1, the ALU
// works combinationally on S1, and the result is registered in stage S2 and
// returned tagged with the requester ID. A single consumer backpressures S2.
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   -> round-robin on ties (last_grant pointer,
//                               reset to 1 so requester 0 wins first tie)
//                  undefined -> fixed priority, requester 0 always wins ties
//
// Ports:
//   Clock, Reset_n            rising-edge clock, async active-low reset
//   ReqValid0/1, ReqReady0/1  request handshake per requester
//   Opcode0/1  [6:0]          RV32I opcode
//   Funct0/1   [2:0]          funct3
//   AddRshift0/1              funct7[5] (SUB / SRA select)
//   A0, B0, A1, B1 [XLEN-1:0] operands (B already immediate-muxed)
//   RespValid, RespReady      response handshake
//   RespId                    requester that issued the result
//   RespOut   [XLEN-1:0]      ALU result
//   RespZero                  ALU result == 0
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            Clock,
    input  logic            Reset_n,

    input  logic            ReqValid0,
    output logic            ReqReady0,
    input  logic [6:0]      Opcode0,
    input  logic [2:0]      Funct0,
    input  logic            AddRshift0,
    input  logic [XLEN-1:0] A0,
    input  logic [XLEN-1:0] B0,

    input  logic            ReqValid1,
    output logic            ReqReady1,
    input  logic [6:0]      Opcode1,
    input  logic [2:0]      Funct1,
    input  logic            AddRshift1,
    input  logic [XLEN-1:0] A1,
    input  logic [XLEN-1:0] B1,

    output logic            RespValid,
    input  logic            RespReady,
    output logic            RespId,
    output logic [XLEN-1:0] RespOut,
    output logic            RespZero
);

    // RV32I opcodes
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

    // Arithmetic funct3
    localparam logic [2:0] FNC_ADD_SUB = 3'b000;
    localparam logic [2:0] FNC_SLL     = 3'b001;
    localparam logic [2:0] FNC_SLT     = 3'b010;
    localparam logic [2:0] FNC_SLTU    = 3'b011;
    localparam logic [2:0] FNC_XOR     = 3'b100;
    localparam logic [2:0] FNC_SRL_SRA = 3'b101;
    localparam logic [2:0] FNC_OR      = 3'b110;
    localparam logic [2:0] FNC_AND     = 3'b111;

    // Branch funct3
    localparam logic [2:0] FNC_BEQ  = 3'b000;
    localparam logic [2:0] FNC_BNE  = 3'b001;
    localparam logic [2:0] FNC_BLT  = 3'b100;
    localparam logic [2:0] FNC_BGE  = 3'b101;
    localparam logic [2:0] FNC_BLTU = 3'b110;
    localparam logic [2:0] FNC_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_COPY_B
    } alu_op_t;

    // -------------------------------------------------------------------------
    // Stage S1: operand register
    // -------------------------------------------------------------------------
    logic            s1_v;
    logic [6:0]      s1_opcode;
    logic [2:0]      s1_funct;
    logic            s1_ars;
    logic [XLEN-1:0] s1_a;
    logic [XLEN-1:0] s1_b;
    logic            s1_id;

    logic            s1_adv;
    logic            s2_adv;
    logic            grant0;
    logic            grant1;
    logic            acc0;
    logic            acc1;

    alu_op_t         alu_op;
    logic [XLEN-1:0] alu_out;
    logic            alu_zero;
    logic [4:0]      shamt;

    // S2 is free when empty or being drained; S1 is free when empty or
    // when it can move into S2.
    assign s2_adv = !RespValid || RespReady;
    assign s1_adv = !s1_v || s2_adv;

    // -------------------------------------------------------------------------
    // Grant
    // -------------------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
    logic last_grant;

    // On a tie the requester that did not win the last accept goes next.
    assign grant0 = ReqValid0 && (!ReqValid1 || last_grant);
    assign grant1 = ReqValid1 && (!ReqValid0 || !last_grant);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            last_grant <= 1'b1;
        end else if (acc0) begin
            last_grant <= 1'b0;
        end else if (acc1) begin
            last_grant <= 1'b1;
        end
    end
`else
    assign grant0 = ReqValid0;
    assign grant1 = ReqValid1 && !ReqValid0;
`endif

    // Ready is held low while reset is asserted even though S1 reads empty.
    assign ReqReady0 = Reset_n && s1_adv && grant0;
    assign ReqReady1 = Reset_n && s1_adv && grant1;

    assign acc0 = ReqValid0 && ReqReady0;
    assign acc1 = ReqValid1 && ReqReady1;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_v      <= 1'b0;
            s1_opcode <= '0;
            s1_funct  <= '0;
            s1_ars    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= 1'b0;
        end else if (acc0) begin
            s1_v      <= 1'b1;
            s1_opcode <= Opcode0;
            s1_funct  <= Funct0;
            s1_ars    <= AddRshift0;
            s1_a      <= A0;
            s1_b      <= B0;
            s1_id     <= 1'b0;
        end else if (acc1) begin
            s1_v      <= 1'b1;
            s1_opcode <= Opcode1;
            s1_funct  <= Funct1;
            s1_ars    <= AddRshift1;
            s1_a      <= A1;
            s1_b      <= B1;
            s1_id     <= 1'b1;
        end else if (s1_adv) begin
            s1_v      <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // ALU decoder on S1
    // -------------------------------------------------------------------------
    always_comb begin
        alu_op = ALU_ADD;
        case (s1_opcode)
            OPC_LUI: alu_op = ALU_COPY_B;
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: alu_op = ALU_ADD;
            OPC_BRANCH: begin
                case (s1_funct)
                    FNC_BEQ, FNC_BNE:   alu_op = ALU_SUB;
                    FNC_BLT, FNC_BGE:   alu_op = ALU_SLT;
                    FNC_BLTU, FNC_BGEU: alu_op = ALU_SLTU;
                    default:            alu_op = ALU_ADD;
                endcase
            end
            OPC_ARI_RTYPE, OPC_ARI_ITYPE: begin
                case (s1_funct)
                    // ADDI ignores bit 30: it belongs to the immediate there.
                    FNC_ADD_SUB: alu_op = (s1_opcode == OPC_ARI_RTYPE && s1_ars)
                                          ? ALU_SUB : ALU_ADD;
                    FNC_SLL:     alu_op = ALU_SLL;
                    FNC_SLT:     alu_op = ALU_SLT;
                    FNC_SLTU:    alu_op = ALU_SLTU;
                    FNC_XOR:     alu_op = ALU_XOR;
                    FNC_SRL_SRA: alu_op = s1_ars ? ALU_SRA : ALU_SRL;
                    FNC_OR:      alu_op = ALU_OR;
                    FNC_AND:     alu_op = ALU_AND;
                    default:     alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

    // -------------------------------------------------------------------------
    // ALU on S1
    // -------------------------------------------------------------------------
    assign shamt = s1_b[4:0];

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD:    alu_out = s1_a + s1_b;
            ALU_SUB:    alu_out = s1_a - s1_b;
            ALU_SLL:    alu_out = s1_a << shamt;
            ALU_SLT:    alu_out = {{(XLEN-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            ALU_SLTU:   alu_out = {{(XLEN-1){1'b0}}, (s1_a < s1_b)};
            ALU_XOR:    alu_out = s1_a ^ s1_b;
            ALU_SRL:    alu_out = s1_a >> shamt;
            ALU_SRA:    alu_out = $signed(s1_a) >>> shamt;
            ALU_OR:     alu_out = s1_a | s1_b;
            ALU_AND:    alu_out = s1_a & s1_b;
            ALU_COPY_B: alu_out = s1_b;
            default:    alu_out = '0;
        endcase
    end

    assign alu_zero = (alu_out == '0);

    // -------------------------------------------------------------------------
    // Stage S2: result register, holds bit-exact while stalled
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RespValid <= 1'b0;
            RespOut   <= '0;
            RespZero  <= 1'b0;
            RespId    <= 1'b0;
        end else if (s2_adv) begin
            RespValid <= s1_v;
            RespOut   <= alu_out;
            RespZero  <= alu_zero;
            RespId    <= s1_id;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. Inputs are driven and outputs sampled on the
// falling clock edge; combinational ready is sampled 1 time unit after inputs
// change. Define ALU_ARB_RR_EN for both RTL and bench to exercise the
// round-robin build; otherwise the fixed-priority scenario runs.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

    logic            Clock;
    logic            Reset_n;
    logic            ReqValid0, ReqValid1;
    logic            ReqReady0, ReqReady1;
    logic [6:0]      Opcode0, Opcode1;
    logic [2:0]      Funct0, Funct1;
    logic            AddRshift0, AddRshift1;
    logic [XLEN-1:0] A0, B0, A1, B1;
    logic            RespValid;
    logic            RespReady;
    logic            RespId;
    logic [XLEN-1:0] RespOut;
    logic            RespZero;

    int n_vec;
    int n_err;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .ReqValid0  (ReqValid0),
        .ReqReady0  (ReqReady0),
        .Opcode0    (Opcode0),
        .Funct0     (Funct0),
        .AddRshift0 (AddRshift0),
        .A0         (A0),
        .B0         (B0),
        .ReqValid1  (ReqValid1),
        .ReqReady1  (ReqReady1),
        .Opcode1    (Opcode1),
        .Funct1     (Funct1),
        .AddRshift1 (AddRshift1),
        .A1         (A1),
        .B1         (B1),
        .RespValid  (RespValid),
        .RespReady  (RespReady),
        .RespId     (RespId),
        .RespOut    (RespOut),
        .RespZero   (RespZero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic clear_inputs();
        ReqValid0 = 1'b0; Opcode0 = '0; Funct0 = '0; AddRshift0 = 1'b0; A0 = '0; B0 = '0;
        ReqValid1 = 1'b0; Opcode1 = '0; Funct1 = '0; AddRshift1 = 1'b0; A1 = '0; B1 = '0;
        RespReady = 1'b1;
    endtask

    task automatic drive0(input logic v, input logic [6:0] opc, input logic [2:0] f,
                          input logic ars, input logic [31:0] a, input logic [31:0] b);
        ReqValid0 = v; Opcode0 = opc; Funct0 = f; AddRshift0 = ars; A0 = a; B0 = b;
    endtask

    task automatic drive1(input logic v, input logic [6:0] opc, input logic [2:0] f,
                          input logic ars, input logic [31:0] a, input logic [31:0] b);
        ReqValid1 = v; Opcode1 = opc; Funct1 = f; AddRshift1 = ars; A1 = a; B1 = b;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        @(negedge Clock);
        Reset_n = 1'b0;
        clear_inputs();
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        ReqValid0 = 1'b1;
        ReqValid1 = 1'b1;
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        @(negedge Clock);
        #1;
        n_vec++; if (ReqReady0 !== 1'b0) begin n_err++; $display("FAIL reset_ready0 got %b want 0", ReqReady0); end
        n_vec++; if (ReqReady1 !== 1'b0) begin n_err++; $display("FAIL reset_ready1 got %b want 0", ReqReady1); end
        n_vec++; if (RespValid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", RespValid); end
        n_vec++; if (RespOut !== 32'h0) begin n_err++; $display("FAIL reset_out got %h want 0", RespOut); end
        n_vec++; if (RespId !== 1'b0) begin n_err++; $display("FAIL reset_id got %b want 0", RespId); end
        n_vec++; if (RespZero !== 1'b0) begin n_err++; $display("FAIL reset_zero got %b want 0", RespZero); end
        clear_inputs();
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    task automatic test_single_add();
        do_reset();
        drive0(1'b1, OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd5, 32'd7);
        #1;
        n_vec++; if (ReqReady0 !== 1'b1) begin n_err++; $display("FAIL add_ready0 got %b want 1", ReqReady0); end
        @(negedge Clock);
        ReqValid0 = 1'b0;
        #1;
        n_vec++; if (RespValid !== 1'b0) begin n_err++; $display("FAIL add_early_valid got %b want 0", RespValid); end
        @(negedge Clock);
        n_vec++; if (RespValid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", RespValid); end
        n_vec++; if (RespOut !== 32'd12) begin n_err++; $display("FAIL add_out got %0d want 12", RespOut); end
        n_vec++; if (RespId !== 1'b0) begin n_err++; $display("FAIL add_id got %b want 0", RespId); end
        n_vec++; if (RespZero !== 1'b0) begin n_err++; $display("FAIL add_zero got %b want 0", RespZero); end
        @(negedge Clock);
        n_vec++; if (RespValid !== 1'b0) begin n_err++; $display("FAIL add_after_valid got %b want 0", RespValid); end
    endtask

    task automatic test_zero_flag();
        do_reset();
        drive1(1'b1, OPC_BRANCH, 3'b000, 1'b0, 32'h10, 32'h10);
        #1;
        n_vec++; if (ReqReady1 !== 1'b1) begin n_err++; $display("FAIL beq_ready1 got %b want 1", ReqReady1); end
        @(negedge Clock);
        ReqValid1 = 1'b0;
        @(negedge Clock);
        n_vec++; if (RespValid !== 1'b1) begin n_err++; $display("FAIL beq_valid got %b want 1", RespValid); end
        n_vec++; if (RespOut !== 32'h0) begin n_err++; $display("FAIL beq_out got %h want 0", RespOut); end
        n_vec++; if (RespZero !== 1'b1) begin n_err++; $display("FAIL beq_zero got %b want 1", RespZero); end
        n_vec++; if (RespId !== 1'b1) begin n_err++; $display("FAIL beq_id got %b want 1", RespId); end
    endtask

    // One op per cycle from requester 0; results appear two falling edges later.
    task automatic test_back_to_back();
        logic [6:0]  opc [7];
        logic [2:0]  fn  [7];
        logic        ars [7];
        logic [31:0] va  [7];
        logic [31:0] vb  [7];
        logic [31:0] exp_out [7];
        logic        exp_z   [7];
        // SUB 5-7
        opc[0] = OPC_ARI_RTYPE; fn[0] = 3'b000; ars[0] = 1'b1; va[0] = 32'd5;        vb[0] = 32'd7;
        exp_out[0] = 32'hFFFF_FFFE; exp_z[0] = 1'b0;
        // SRAI 0x80000000 >>> 4
        opc[1] = OPC_ARI_ITYPE; fn[1] = 3'b101; ars[1] = 1'b1; va[1] = 32'h8000_0000; vb[1] = 32'd4;
        exp_out[1] = 32'hF800_0000; exp_z[1] = 1'b0;
        // SLTU 1 < 0xFFFFFFFF
        opc[2] = OPC_ARI_RTYPE; fn[2] = 3'b011; ars[2] = 1'b0; va[2] = 32'd1;        vb[2] = 32'hFFFF_FFFF;
        exp_out[2] = 32'd1; exp_z[2] = 1'b0;
        // LUI passes B
        opc[3] = OPC_LUI;       fn[3] = 3'b000; ars[3] = 1'b0; va[3] = 32'h1234;     vb[3] = 32'hABCD_E000;
        exp_out[3] = 32'hABCD_E000; exp_z[3] = 1'b0;
        // XOR equal operands
        opc[4] = OPC_ARI_RTYPE; fn[4] = 3'b100; ars[4] = 1'b0; va[4] = 32'hF0F0_F0F0; vb[4] = 32'hF0F0_F0F0;
        exp_out[4] = 32'h0; exp_z[4] = 1'b1;
        // ADDI with immediate bit 30 set still adds
        opc[5] = OPC_ARI_ITYPE; fn[5] = 3'b000; ars[5] = 1'b1; va[5] = 32'd3;        vb[5] = 32'd4;
        exp_out[5] = 32'd7; exp_z[5] = 1'b0;
        // BLT -1 < 1 (signed)
        opc[6] = OPC_BRANCH;    fn[6] = 3'b100; ars[6] = 1'b0; va[6] = 32'hFFFF_FFFF; vb[6] = 32'd1;
        exp_out[6] = 32'd1; exp_z[6] = 1'b0;

        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i >= 2) begin
                n_vec++;
                if (RespValid !== 1'b1 || RespOut !== exp_out[i-2] || RespZero !== exp_z[i-2]) begin
                    n_err++;
                    $display("FAIL b2b_op%0d got v=%b out=%h z=%b want v=1 out=%h z=%b",
                             i-2, RespValid, RespOut, RespZero, exp_out[i-2], exp_z[i-2]);
                end
            end
            if (i < 7) begin
                drive0(1'b1, opc[i], fn[i], ars[i], va[i], vb[i]);
                #1;
                n_vec++; if (ReqReady0 !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d got %b want 1", i, ReqReady0); end
            end else begin
                ReqValid0 = 1'b0;
            end
            @(negedge Clock);
        end
        n_vec++; if (RespValid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", RespValid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive0(1'b1, OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd10, 32'd1);
        @(negedge Clock);                     // B=1 accepted
        B0 = 32'd2;
        @(negedge Clock);                     // 11 in S2, B=2 in S1
        n_vec++; if (RespValid !== 1'b1 || RespOut !== 32'd11) begin
            n_err++; $display("FAIL bp_first got v=%b out=%0d want v=1 out=11", RespValid, RespOut); end
        RespReady = 1'b0;
        B0 = 32'd3;
        #1;
        n_vec++; if (ReqReady0 !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %b want 0", ReqReady0); end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            n_vec++;
            if (RespValid !== 1'b1 || RespOut !== 32'd11 || RespId !== 1'b0 || ReqReady0 !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d got v=%b out=%0d id=%b rdy=%b want v=1 out=11 id=0 rdy=0",
                         k, RespValid, RespOut, RespId, ReqReady0);
            end
        end
        RespReady = 1'b1;
        #1;
        n_vec++; if (ReqReady0 !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", ReqReady0); end
        @(negedge Clock);                     // B=3 accepted, 12 in S2
        n_vec++; if (RespValid !== 1'b1 || RespOut !== 32'd12) begin
            n_err++; $display("FAIL bp_r12 got v=%b out=%0d want v=1 out=12", RespValid, RespOut); end
        B0 = 32'd4;
        @(negedge Clock);
        n_vec++; if (RespValid !== 1'b1 || RespOut !== 32'd13) begin
            n_err++; $display("FAIL bp_r13 got v=%b out=%0d want v=1 out=13", RespValid, RespOut); end
        ReqValid0 = 1'b0;
        @(negedge Clock);
        n_vec++; if (RespValid !== 1'b1 || RespOut !== 32'd14) begin
            n_err++; $display("FAIL bp_r14 got v=%b out=%0d want v=1 out=14", RespValid, RespOut); end
        @(negedge Clock);
        n_vec++; if (RespValid !== 1'b0) begin n_err++; $display("FAIL bp_extra got %b want 0", RespValid); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        drive0(1'b1, OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd1, 32'd1);
        @(negedge Clock);
        A0 = 32'd2; B0 = 32'd2;
        @(negedge Clock);                     // S2 and S1 both valid
        ReqValid0 = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        n_vec++; if (RespValid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got %b want 0", RespValid); end
        @(negedge Clock);
        Reset_n = 1'b1;
        drive0(1'b1, OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd40, 32'd2);
        drive1(1'b1, OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd50, 32'd3);
        #1;
        n_vec++; if (ReqReady0 !== 1'b1 || ReqReady1 !== 1'b0) begin
            n_err++; $display("FAIL rst_tie got rdy0=%b rdy1=%b want 1 0", ReqReady0, ReqReady1); end
        @(negedge Clock);
        ReqValid0 = 1'b0;
        ReqValid1 = 1'b0;
        #1;
        n_vec++; if (RespValid !== 1'b0) begin n_err++; $display("FAIL rst_stale got %b want 0", RespValid); end
        @(negedge Clock);
        n_vec++; if (RespValid !== 1'b1 || RespId !== 1'b0 || RespOut !== 32'd42) begin
            n_err++; $display("FAIL rst_first got v=%b id=%b out=%0d want v=1 id=0 out=42", RespValid, RespId, RespOut); end
    endtask

`ifdef ALU_ARB_RR_EN
    task automatic test_round_robin();
        logic exp_id [4];
        exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
        do_reset();
        drive0(1'b1, OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd100, 32'd0);
        drive1(1'b1, OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd200, 32'd0);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i < 4) begin
                n_vec++;
                if (ReqReady0 !== !exp_id[i] || ReqReady1 !== exp_id[i]) begin
                    n_err++; $display("FAIL rr_grant%0d got rdy0=%b rdy1=%b want rdy1=%b", i, ReqReady0, ReqReady1, exp_id[i]);
                end
            end
            if (i >= 2) begin
                n_vec++;
                if (RespValid !== 1'b1 || RespId !== exp_id[i-2] || RespOut !== (exp_id[i-2] ? 32'd200 : 32'd100)) begin
                    n_err++; $display("FAIL rr_resp%0d got v=%b id=%b out=%0d want v=1 id=%b", i-2, RespValid, RespId, RespOut, exp_id[i-2]);
                end
            end
            @(negedge Clock);
            if (i == 3) begin
                ReqValid0 = 1'b0;
                ReqValid1 = 1'b0;
            end
        end
        n_vec++; if (RespValid !== 1'b0) begin n_err++; $display("FAIL rr_drain got %b want 0", RespValid); end
    endtask
`else
    task automatic test_fixed_priority();
        do_reset();
        drive0(1'b1, OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd100, 32'd0);
        drive1(1'b1, OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd200, 32'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i < 3) begin
                n_vec++;
                if (ReqReady0 !== 1'b1 || ReqReady1 !== 1'b0) begin
                    n_err++; $display("FAIL fp_grant%0d got rdy0=%b rdy1=%b want 1 0", i, ReqReady0, ReqReady1);
                end
            end
            if (i >= 2) begin
                n_vec++;
                if (RespValid !== 1'b1 || RespId !== 1'b0 || RespOut !== 32'd100) begin
                    n_err++; $display("FAIL fp_resp%0d got v=%b id=%b out=%0d want v=1 id=0 out=100", i-2, RespValid, RespId, RespOut);
                end
            end
            @(negedge Clock);
            if (i == 2) ReqValid0 = 1'b0;
            if (i == 3) begin
                #1;
                n_vec++; if (ReqReady1 !== 1'b1) begin n_err++; $display("FAIL fp_req1_grant got %b want 1", ReqReady1); end
            end
        end
        // After edge accepting req1 (first cycle req0 was low) plus one more.
        ReqValid1 = 1'b0;
        @(negedge Clock);
        n_vec++; if (RespValid !== 1'b1 || RespId !== 1'b1 || RespOut !== 32'd200) begin
            n_err++; $display("FAIL fp_req1_resp got v=%b id=%b out=%0d want v=1 id=1 out=200", RespValid, RespId, RespOut); end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset_n = 1'b1;
        clear_inputs();
        test_reset();
        test_single_add();
        test_zero_flag();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef ALU_ARB_RR_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and pipeline sequencer that shares the single RV32I `ALU`/`ALUdec` pair between the execute stage (requester 0) and the branch/address unit (requester 1). Each requester presents an opcode/funct/`add_rshift_type` plus operands under a valid/ready handshake. The block grants one request per cycle, registers the operands, drives the shared ALU, and returns the registered result tagged with the requester ID. Backpressure comes from a single response consumer.

## Interface
- `XLEN`, 32, operand/result width (ALU is 32-bit; only 32 is supported)
- `Clock`  in  1  rising-edge clock
- `Reset_n`  in  1  asynchronous, active-low reset
- `ReqValid0` / `ReqValid1`  in  1  request present
- `ReqReady0` / `ReqReady1`  out  1  request accepted this cycle when paired with valid
- `Opcode0` / `Opcode1`  in  7  RV32I opcode
- `Funct0` / `Funct1`  in  3  funct3
- `AddRshift0` / `AddRshift1`  in  1  funct7[5] (SUB/SRA select)
- `A0`, `B0` / `A1`, `B1`  in  XLEN  operands (B already immediate-muxed)
- `RespValid`  out  1  result available
- `RespReady`  in  1  consumer takes result
- `RespId`  out  1  requester that issued the result
- `RespOut`  out  XLEN  ALU result
- `RespZero`  out  1  ALU `Zero` for that result

## Operation
- Pipeline stage S1 holds the operand register: opcode, funct, add_rshift_type, A, B, id, valid `s1_v`. `ALUdec`+`ALU` sit combinationally on S1.
- Pipeline stage S2 holds the result register: `RespOut`, `RespZero`, `RespId`, `RespValid` (= `s2_v`).
- `s2_adv` = `!s2_v || RespReady`. `s1_adv` = `!s1_v || s2_adv`.
- Grant logic:
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to `last_grant` is granted.
  - `ReqReadyN` = `s1_adv && grantN`. Ready is never asserted to a non-granted requester.
- Accept (`ReqValidN && ReqReadyN`): load S1 and set `last_grant <= N`. `last_grant` changes only on an accept.
- On `s2_adv`: S2 loads the ALU output and `s1_v`. S1 clears if nothing is accepted the same cycle.
- Requester rule: once valid is asserted, valid and payload are held until accepted. The block never drops an accepted request.
- No decode checking. Unsupported opcodes produce whatever `ALUdec` yields.

## Timing
- Reset (async assert, sync deassert by the surrounding reset tree):
  - `s1_v`=0, `RespValid`=0, `RespOut`=0, `RespZero`=0, `RespId`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - `ReqReady*` is 0 during reset.
- Latency: accepted at edge N → `RespValid`=1 after edge N+1 (2-cycle fixed latency with no stall).
- Throughput: 1 result/cycle with `RespReady` held high and continuous requests.
- Stall: with `RespValid && !RespReady`, S2 holds bit-exact. If `s1_v`, S1 also holds and both `ReqReady*`=0.
- Simultaneous drain + accept: S2 pops, S1 moves to S2, and the new request loads S1 in the same cycle.
- Reset mid-operation: in-flight S1/S2 contents are discarded with no response, and the round-robin pointer returns to 1.

## Configuration
- `ALU_ARB_RR_EN`
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, requester 0 always wins ties. `last_grant` is removed, and requester 1 is granted only when `ReqValid0`=0.

## Test plan
- Single ADD: req0 ADD (`OPC_ARI_RTYPE`, `FNC_ADD_SUB`, AddRshift=0), A=5, B=7, RespReady=1.
  - Expect `ReqReady0`=1 at the accept edge.
  - Expect RespValid, RespOut=12, RespId=0, RespZero=0 exactly 2 edges later.
- Zero flag: req1 BEQ, A=B=0x10.
  - Expect RespOut=0, RespZero=1, RespId=1.
- Tie, round-robin (`ALU_ARB_RR_EN` defined): both requesters valid continuously for 4 transfers.
  - Expect RespId sequence 0,1,0,1 and one result per cycle.
- Backpressure: stream req0 ADDs with B=1..4 and drop RespReady for 3 cycles after the first RespValid.
  - Expect RespOut=A+1 held stable.
  - Expect `ReqReady0`=0 once S1 is full.
  - On release, expect results A+2, A+3, A+4 in order, none lost or duplicated.
- Reset mid-flight: assert Reset_n=0 while S1 and S2 are both valid.
  - Expect RespValid=0 immediately (asynchronously).
  - After release, a tie grants requester 0 first.
- Fixed priority (macro undefined): both valid for 3 transfers.
  - Expect RespId 0,0,0 and `ReqReady1`=0 throughout.
  - Drop req0: req1 is granted on the next cycle.
